// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types for the data-memory port arbiter
package dmem_arb_pkg;

    // Owner of the read issued last cycle, steering the 1-cycle SRAM return.
    typedef enum logic [1:0] {RD_NONE, RD_CORE, RD_LD} rd_tag_t;

    typedef enum logic {S_ARB, S_FORCE} arb_state_t;

    // Wide enough for MAX_WAIT up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_starve_cnt.sv
// rtl/dmem_starve_cnt.sv - counts consecutive denied loader cycles, flags the forcing one
module dmem_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic incEn,
    output logic forcePulse
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] waitCnt;

    // Any cycle without a denial (loader served, loader idle, forced beat) restarts the count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            waitCnt <= '0;
        end else if (!incEn) begin
            waitCnt <= '0;
        end else if (waitCnt != LIMIT) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

    assign forcePulse = incEn && (waitCnt >= (LIMIT - 1'b1));

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - core/loader arbiter for the single-port data SRAM
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wmask,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t state, nextState;
    rd_tag_t    rdTag, rdTagNext;
    logic       coreGnt, ldGnt, cntInc, forcePulse;

    assign cntInc = rstn && (state == S_ARB) && core_req && ld_req;

    dmem_starve_cnt #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve (
        .clk       (clk),
        .rstn      (rstn),
        .incEn     (cntInc),
        .forcePulse(forcePulse)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_ARB;
            rdTag <= RD_NONE;
        end else begin
            state <= nextState;
            rdTag <= rdTagNext;
        end
    end

    // Core wins in ARB; FORCE hands exactly one beat to the loader and stalls the core.
    always_comb begin
        nextState  = S_ARB;
        coreGnt    = 1'b0;
        ldGnt      = 1'b0;
        core_stall = 1'b0;
        if (rstn) begin
            unique case (state)
                S_ARB: begin
                    if (core_req) begin
                        coreGnt = 1'b1;
                        if (forcePulse) nextState = S_FORCE;
                    end else begin
                        ldGnt = ld_req;
                    end
                end
                S_FORCE: begin
                    ldGnt      = ld_req;
                    core_stall = core_req;
                end
                default: ;
            endcase
        end
    end

    assign ld_gnt = ldGnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wmask = '0;
        mem_wdata = '0;
        rdTagNext = RD_NONE;
        if (coreGnt) begin
            mem_en   = 1'b1;
            mem_we   = core_we;
            mem_addr = core_addr;
            if (core_we) begin
                mem_wmask = core_wmask;
                mem_wdata = core_wdata;
            end else begin
                rdTagNext = RD_CORE;
            end
        end else if (ldGnt) begin
            mem_en   = 1'b1;
            mem_we   = ld_we;
            mem_addr = ld_addr;
            if (ld_we) begin
                mem_wmask = '1;
                mem_wdata = ld_wdata;
            end else begin
                rdTagNext = RD_LD;
            end
        end
    end

    // Gating with rstn drops a return whose read was issued the cycle before reset.
    assign core_rvalid = rstn && (rdTag == RD_CORE);
    assign ld_rvalid   = rstn && (rdTag == RD_LD);
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign ld_rdata    = ld_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        core_req, core_we;
    logic [11:0] core_addr;
    logic [31:0] core_wmask, core_wdata;
    logic        core_stall, core_rvalid;
    logic [31:0] core_rdata;
    logic        ld_req, ld_we;
    logic [11:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_gnt, ld_rvalid;
    logic [31:0] ld_rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wmask, mem_wdata;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rstn(rstn),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wmask(core_wmask), .core_wdata(core_wdata),
        .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_val(input int a);
        case (a)
            'h010:   return 32'hDEADBEEF;
            'h030:   return 32'h30303030;
            'h031:   return 32'h31313131;
            default: return 32'hFFFFFFFF;
        endcase
    endfunction

    // SRAM environment: registered read, bit-masked write.
    logic [31:0] sram [0:4095];
    bit preloaded = 1'b0;
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 4096; i++) sram[i] <= init_val(i);
            preloaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) sram[mem_addr] <= (sram[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
            else mem_rdata <= sram[mem_addr];
        end
    end

    typedef struct {
        logic [31:0] rstn, creq, cwe, caddr, cwmask, cwdata, lreq, lwe, laddr, lwdata;
        logic [31:0] egnt, estall, een, ewe, eaddr, ewmask, ewdata, ecrv, ecrd, elrv, elrd;
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Reference model: served-owner decision, denial count, shadow memory, pending return.
    logic [31:0] shadow [0:4095];
    int  mDenied = 0;
    bit  mForce = 1'b0;
    int  mPend = 0;  // 0 none, 1 core, 2 loader
    logic [31:0] mPendData = '0;
    bit  eCoreSrv, eLdSrv, lastLdSrv = 1'b0;
    logic [31:0] eGnt, eStall, eEn, eWe, eAddr, eWmask, eWdata, eCrv, eCrd, eLrv, eLrd;

    task automatic model_expect();
        eCoreSrv = 0; eLdSrv = 0; eStall = 0;
        eEn = 0; eWe = 0; eAddr = 0; eWmask = 0; eWdata = 0;
        eCrv = 0; eCrd = 0; eLrv = 0; eLrd = 0;
        if (rstn) begin
            if (mForce) begin
                eLdSrv = ld_req;
                eStall = 32'(core_req);
            end else if (core_req) eCoreSrv = 1;
            else eLdSrv = ld_req;
            if (eCoreSrv) begin
                eEn = 1; eWe = 32'(core_we); eAddr = 32'(core_addr);
                if (core_we) begin eWmask = core_wmask; eWdata = core_wdata; end
            end else if (eLdSrv) begin
                eEn = 1; eWe = 32'(ld_we); eAddr = 32'(ld_addr);
                if (ld_we) begin eWmask = 32'hFFFFFFFF; eWdata = ld_wdata; end
            end
            if (mPend == 1) begin eCrv = 1; eCrd = mPendData; end
            if (mPend == 2) begin eLrv = 1; eLrd = mPendData; end
        end
        eGnt = 32'(eLdSrv);
    endtask

    task automatic model_update();
        lastLdSrv = eLdSrv;
        mPend = 0;
        if (!rstn) begin
            mDenied = 0;
            mForce = 0;
            return;
        end
        if (eEn != 0) begin
            if (eWe != 0) shadow[eAddr[11:0]] = (shadow[eAddr[11:0]] & ~eWmask) | (eWdata & eWmask);
            else begin
                mPend = eCoreSrv ? 1 : 2;
                mPendData = shadow[eAddr[11:0]];
            end
        end
        if (eCoreSrv && ld_req) begin
            mDenied++;
            mForce = (mDenied == MAXW);
            if (mForce) mDenied = 0;
        end else begin
            mDenied = 0;
            mForce = 0;
        end
    endtask

    task automatic compare_outputs(input string tag, input logic [31:0] g, st, en, we, ad, wm, wd,
                                   crv, crd, lrv, lrd);
        chk({tag, ".ld_gnt"},      32'(ld_gnt),      g);
        chk({tag, ".core_stall"},  32'(core_stall),  st);
        chk({tag, ".mem_en"},      32'(mem_en),      en);
        chk({tag, ".mem_we"},      32'(mem_we),      we);
        chk({tag, ".mem_addr"},    32'(mem_addr),    ad);
        chk({tag, ".mem_wmask"},   mem_wmask,        wm);
        chk({tag, ".mem_wdata"},   mem_wdata,        wd);
        chk({tag, ".core_rvalid"}, 32'(core_rvalid), crv);
        chk({tag, ".core_rdata"},  core_rdata,       crd);
        chk({tag, ".ld_rvalid"},   32'(ld_rvalid),   lrv);
        chk({tag, ".ld_rdata"},    ld_rdata,         lrd);
    endtask

    task automatic run_cycle(input bit useTable, input vec_t v, input int idx);
        @(negedge clk);
        model_expect();
        if (useTable)
            compare_outputs($sformatf("vec%0d", idx), v.egnt, v.estall, v.een, v.ewe, v.eaddr,
                            v.ewmask, v.ewdata, v.ecrv, v.ecrd, v.elrv, v.elrd);
        else
            compare_outputs($sformatf("rand%0d", idx), eGnt, eStall, eEn, eWe, eAddr,
                            eWmask, eWdata, eCrv, eCrd, eLrv, eLrd);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        rstn = v.rstn[0]; core_req = v.creq[0]; core_we = v.cwe[0]; core_addr = v.caddr[11:0];
        core_wmask = v.cwmask; core_wdata = v.cwdata;
        ld_req = v.lreq[0]; ld_we = v.lwe[0]; ld_addr = v.laddr[11:0]; ld_wdata = v.lwdata;
    endtask

    localparam logic [31:0] F = 32'hFFFFFFFF;
    vec_t vecs [20];
    vec_t dummy;

    initial begin
        for (int i = 0; i < 4096; i++) shadow[i] = init_val(i);
        dummy = '{default: '0};
        // inputs: rstn creq cwe caddr cwmask cwdata lreq lwe laddr lwdata
        // expect: gnt stall en we addr wmask wdata crv crd lrv lrd
        for (int i = 0; i < 3; i++)
            vecs[i] = '{0,1,0,'h010,0,0,1,1,'h020,'h12345678, 0,0,0,0,0,0,0, 0,0,0,0};
        vecs[3]  = '{1,1,0,'h010,0,0,0,0,0,0, 0,0,1,0,'h010,0,0, 0,0,0,0};
        vecs[4]  = '{1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 1,'hDEADBEEF,0,0};
        vecs[5]  = '{1,1,0,'h011,0,0,1,1,'h020,'h12345678, 0,0,1,0,'h011,0,0, 0,0,0,0};
        for (int i = 6; i < 9; i++)
            vecs[i] = '{1,1,0,'h011,0,0,1,1,'h020,'h12345678, 0,0,1,0,'h011,0,0, 1,F,0,0};
        vecs[9]  = '{1,1,0,'h011,0,0,1,1,'h020,'h12345678, 1,1,1,1,'h020,F,'h12345678, 1,F,0,0};
        vecs[10] = '{1,1,0,'h020,0,0,0,0,0,0, 0,0,1,0,'h020,0,0, 0,0,0,0};
        vecs[11] = '{1,0,0,0,0,0,1,0,'h030,0, 1,0,1,0,'h030,0,0, 1,'h12345678,0,0};
        vecs[12] = '{1,1,0,'h031,0,0,0,0,0,0, 0,0,1,0,'h031,0,0, 0,0,1,'h30303030};
        vecs[13] = '{1,1,1,'h040,'h0000FFFF,'hAAAA5555,0,0,0,0, 0,0,1,1,'h040,'h0000FFFF,'hAAAA5555, 1,'h31313131,0,0};
        vecs[14] = '{1,1,0,'h040,0,0,0,0,0,0, 0,0,1,0,'h040,0,0, 0,0,0,0};
        vecs[15] = '{1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 1,'hFFFF5555,0,0};
        vecs[16] = '{1,0,0,0,0,0,1,0,'h030,0, 1,0,1,0,'h030,0,0, 0,0,0,0};
        vecs[17] = '{0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0};
        vecs[18] = '{1,1,0,'h010,0,0,0,0,0,0, 0,0,1,0,'h010,0,0, 0,0,0,0};
        vecs[19] = '{1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 1,'hDEADBEEF,0,0};

        apply(vecs[0]);
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            apply(vecs[i]);
            run_cycle(1'b1, vecs[i], i);
        end

        // Randomized traffic on a small address window; the loader holds its request until served.
        ld_req = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rstn = ($urandom_range(0, 149) != 0) && (n > 1);
            core_req   = ($urandom_range(0, 3) != 0);
            core_we    = $urandom_range(0, 1) == 1;
            core_addr  = 12'($urandom_range(0, 31));
            core_wmask = $urandom;
            core_wdata = $urandom;
            if (!ld_req || lastLdSrv) begin
                ld_req   = ($urandom_range(0, 2) != 0);
                ld_we    = $urandom_range(0, 1) == 1;
                ld_addr  = 12'($urandom_range(0, 31));
                ld_wdata = $urandom;
            end
            run_cycle(1'b0, dummy, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data SRAM between two requesters:
  - the core load/store path (Execute address, MemRd return);
  - a loader/debug port (testbench preload, debug peek/poke).
- Core normally has priority and sees zero-stall access.
- The loader is guaranteed forward progress by a starvation counter that forces one loader beat.
- Tracks the owner of each in-flight read so the 1-cycle SRAM read data returns to the correct requester.

Parameters:
- ADDR_W, 12, word address width of data SRAM
- DATA_W, 32, data and bit-mask width
- MAX_WAIT, 4, consecutive denied loader cycles before a forced loader beat (1..15)

Ports:
- clk  in  1  core clock (clkMem domain)
- rstn  in  1  reset
- core_req  in  1  core access request this cycle
- core_we  in  1  1=write, 0=read
- core_addr  in  ADDR_W  core word address
- core_wmask  in  DATA_W  per-bit write mask (1=write bit)
- core_wdata  in  DATA_W  core write data
- core_stall  out  1  core request not served this cycle
- core_rvalid  out  1  core read data valid
- core_rdata  out  DATA_W  core read data
- ld_req  in  1  loader request, held until ld_gnt
- ld_we  in  1  loader write
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data (full-word write)
- ld_gnt  out  1  loader beat accepted this cycle
- ld_rvalid  out  1  loader read data valid
- ld_rdata  out  DATA_W  loader read data
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wmask  out  DATA_W  SRAM bit mask
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid 1 cycle after read enable

Behaviour:
- Clocking/reset: one clock, clk; reset rstn is synchronous, active-low.
- While rstn=0, forced regardless of inputs:
  - outputs: mem_en=0, mem_we=0, core_stall=0, ld_gnt=0, core_rvalid=0, ld_rvalid=0; rdata outputs=0.
  - internal: state=ARB, wait_cnt=0, rd_tag=NONE.
- Grant decision is combinational within the cycle; mem_* are driven from the granted requester's inputs in the same cycle.
- FSM states:
  - ARB
    - core_req=1: grant core; ld_gnt=0.
    - core_req=0 and ld_req=1: grant loader, ld_gnt=1.
    - If core granted and ld_req=1: wait_cnt++. If wait_cnt+1==MAX_WAIT, next state=FORCE.
    - Loader granted or ld_req=0: wait_cnt<=0.
  - FORCE
    - Loader granted (ld_gnt=1); core_stall=core_req.
    - wait_cnt<=0; next state=ARB.
    - If ld_req dropped (protocol violation), no grant; mem_en=0; return to ARB.
- core_stall=1 only in FORCE with core_req=1. The core holds its request; it is served next cycle in ARB.
- Loader writes: mem_wmask=all ones. Core writes: mem_wmask=core_wmask. Reads: mem_wmask=0, mem_wdata=0.
- Idle (no grant): mem_en=0; mem_addr/mem_wdata hold 0.
- Read return:
  - rd_tag register <= {CORE, LD, NONE} from the grant owner when the granted access is a read, else NONE.
  - Next cycle: core_rvalid=(rd_tag==CORE), ld_rvalid=(rd_tag==LD).
  - The matching rdata=mem_rdata; the other rdata=0.
  - Back-to-back reads from alternating owners return in order with no bubble.
- Write latency 0: accepted on grant; no response.
- Simultaneous core and loader write to the same address: core wins in ARB, loader wins in FORCE; the later write overwrites.
- Reset mid-operation: a pending rd_tag is cleared. The return for a read issued in the cycle before reset is dropped (no rvalid).

Decomposition:
- Shared package dmem_arb_pkg:
  - typedef enum logic[1:0] {RD_NONE, RD_CORE, RD_LD} rd_tag_t;
  - typedef enum logic {S_ARB, S_FORCE} arb_state_t;
- One sub-module natural: dmem_starve_cnt (wait counter, saturate at MAX_WAIT, force-pulse output).
- Everything else is flat in dmem_port_arbiter.

Test Plan:
1. Reset: hold rstn=0 with core_req=1, ld_req=1 for 3 cycles -> mem_en=0, ld_gnt=0, core_stall=0, all rvalid=0.
2. Core read addr 0x010 (SRAM holds 0xDEADBEEF) -> mem_en=1, mem_addr=0x010 same cycle; next cycle core_rvalid=1, core_rdata=0xDEADBEEF, ld_rvalid=0.
3. Starvation: core_req=1 every cycle, ld_req=1 write 0x020=0x12345678, MAX_WAIT=4 -> ld_gnt=0 for cycles 1-4, ld_gnt=1 and core_stall=1 in cycle 5, core served again in cycle 6; wait_cnt=0.
4. Idle core, loader reads 0x030 then core reads 0x031 next cycle -> ld_rvalid then core_rvalid on consecutive cycles with correct data, no bubble.
5. Core write wmask=0x0000FFFF, wdata=0xAAAA5555 to a word holding 0xFFFFFFFF -> mem_wmask=0x0000FFFF; readback 0xFFFF5555.
6. Reset asserted the cycle after a loader read grant -> ld_rvalid stays 0; after release, first core read returns normally.
